// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: default register-file geometry and the soft-clear state type.
package cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 32;

  typedef enum logic {
    RF_IDLE,
    RF_CLEAR
  } rf_state_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/reg_file_sb_read_port.sv
// One register-file read port: array mux plus the zero-register, write-bypass and stall logic.
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit WR_BYPASS = 1'b1,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DEPTH-1:0][DATA_W-1:0] regs,
  input  logic [DEPTH-1:0]             busy_vec,
  input  logic                         ready,
  input  logic                         write_enable,
  input  logic [ADDR_W-1:0]            rd,
  input  logic [DATA_W-1:0]            write_data,
  output logic [DATA_W-1:0]            data,
  output logic                         busy
);

  logic is_zero;
  logic bypass;

  assign is_zero = ZERO_REG && (addr == '0);

  // Forwarding only happens while IDLE, so a clear in progress always exposes raw storage.
  assign bypass = WR_BYPASS && write_enable && ready && (rd == addr) &&
                  !(ZERO_REG && (rd == '0));

  assign data = is_zero ? '0 : (bypass ? write_data : regs[addr]);
  assign busy = !ready ? 1'b1 : (bypass ? 1'b0 : busy_vec[addr]);

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with per-register busy scoreboard and a sequential soft-clear engine.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NUM_RD    = 2,
  parameter bit ZERO_REG  = 1'b1,
  parameter bit WR_BYPASS = 1'b1,
  localparam int ADDR_W   = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic                     write_enable,
  input  logic [ADDR_W-1:0]        rd,
  input  logic [DATA_W-1:0]        write_data,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_rd,
  input  logic                     clear_req,
  output logic                     ready
);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;
  rf_state_t                    state;
  logic [ADDR_W-1:0]            cnt;
  logic                         wr_ok;
  logic                         iss_ok;

  assign wr_ok  = write_enable && ready && !(ZERO_REG && (rd == '0));
  assign iss_ok = issue_valid && ready && !(ZERO_REG && (issue_rd == '0));

  // Issue is applied after writeback so a new producer to the same index leaves it busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs  <= '0;
      busy  <= '0;
      state <= RF_IDLE;
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      case (state)
        RF_IDLE: begin
          if (wr_ok) begin
            regs[rd] <= write_data;
            busy[rd] <= 1'b0;
          end
          if (iss_ok) busy[issue_rd] <= 1'b1;
          if (clear_req) begin
            state <= RF_CLEAR;
            ready <= 1'b0;
          end
        end
        RF_CLEAR: begin
          regs[cnt] <= '0;
          busy[cnt] <= 1'b0;
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            cnt   <= '0;
            state <= RF_IDLE;
            ready <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RF_IDLE;
          ready <= 1'b1;
          cnt   <= '0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    rf_read_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ZERO_REG (ZERO_REG),
      .WR_BYPASS(WR_BYPASS)
    ) u_port (
      .addr        (rs_addr[i*ADDR_W +: ADDR_W]),
      .regs        (regs),
      .busy_vec    (busy),
      .ready       (ready),
      .write_enable(write_enable),
      .rd          (rd),
      .write_data  (write_data),
      .data        (rs_data[i*DATA_W +: DATA_W]),
      .busy        (rs_busy[i])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed scoreboard bench for reg_file_sb with default geometry (32 x 32 bits, two read ports).
module tb_reg_file_sb;

  logic        clk;
  logic        rst;
  logic [9:0]  rs_addr;
  logic [63:0] rs_data;
  logic [1:0]  rs_busy;
  logic        write_enable;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        clear_req;
  logic        ready;

  int compared   = 0;
  int mismatched = 0;
  int measured   = 0;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rs_addr     (rs_addr),
    .rs_data     (rs_data),
    .rs_busy     (rs_busy),
    .write_enable(write_enable),
    .rd          (rd),
    .write_data  (write_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .clear_req   (clear_req),
    .ready       (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change just after the falling edge, well clear of the active rising edge.
  task automatic applyStimulus(input logic we, input logic [4:0] wr_idx, input logic [31:0] wd,
                               input logic iv, input logic [4:0] iss_idx, input logic clr,
                               input logic [4:0] a0, input logic [4:0] a1);
    @(negedge clk);
    write_enable = we;
    rd           = wr_idx;
    write_data   = wd;
    issue_valid  = iv;
    issue_rd     = iss_idx;
    clear_req    = clr;
    rs_addr      = {a1, a0};
  endtask

  task automatic expectVal(input string tag, input int kind, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.kind  = kind;
    e.value = v;
    sb.push_back(e);
  endtask

  // Kinds: 0 port0 data, 1 port1 data, 2 busy pair, 3 ready, 4 measured counter.
  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        0:       obs = rs_data[31:0];
        1:       obs = rs_data[63:32];
        2:       obs = {30'b0, rs_busy};
        3:       obs = {31'b0, ready};
        default: obs = 32'(measured);
      endcase
      compared++;
      assert (obs === e.value)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
      end
    end
  endtask

  initial begin
    rst          = 1'b0;
    write_enable = 1'b0;
    rd           = '0;
    write_data   = '0;
    issue_valid  = 1'b0;
    issue_rd     = '0;
    clear_req    = 1'b0;
    rs_addr      = {5'd2, 5'd1};
    repeat (2) @(negedge clk);
    rst = 1'b1;

    expectVal("reset_ready", 3, 32'd1);
    expectVal("reset_d0", 0, 32'h0);
    expectVal("reset_d1", 1, 32'h0);
    expectVal("reset_busy", 2, 32'h0);
    checkOutput();

    $display("[TB] basic writes and bypass");
    applyStimulus(1'b1, 5'd1, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
    expectVal("wr1_bypass_d0", 0, 32'hA5A5A5A5);
    expectVal("wr1_raw_d1", 1, 32'h0);
    checkOutput();
    applyStimulus(1'b1, 5'd2, 32'h5A5A5A5A, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
    expectVal("wr2_stored_d0", 0, 32'hA5A5A5A5);
    expectVal("wr2_bypass_d1", 1, 32'h5A5A5A5A);
    checkOutput();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd2);
    expectVal("rd_r1", 0, 32'hA5A5A5A5);
    expectVal("rd_r2", 1, 32'h5A5A5A5A);
    expectVal("rd_busy", 2, 32'h0);
    checkOutput();

    $display("[TB] zero register");
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    expectVal("r0_same_d0", 0, 32'h0);
    expectVal("r0_same_busy", 2, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    expectVal("r0_after_d1", 1, 32'h0);
    expectVal("r0_after_busy", 2, 32'h0);
    checkOutput();

    $display("[TB] scoreboard busy and bypass release");
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd5);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    expectVal("r5_busy", 2, 32'h3);
    checkOutput();
    applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    expectVal("r5_bypass_d0", 0, 32'h12345678);
    expectVal("r5_bypass_busy", 2, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5);
    expectVal("r5_next_d0", 0, 32'h12345678);
    expectVal("r5_next_busy", 2, 32'h0);
    checkOutput();

    $display("[TB] issue and write to same index");
    applyStimulus(1'b1, 5'd7, 32'hCAFEF00D, 1'b1, 5'd7, 1'b0, 5'd7, 5'd7);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd1);
    expectVal("r7_data", 0, 32'hCAFEF00D);
    expectVal("r1_other_port", 1, 32'hA5A5A5A5);
    expectVal("r7_busy_r1_free", 2, 32'h1);
    checkOutput();

    $display("[TB] fill and soft clear");
    for (int i = 1; i < 32; i++)
      applyStimulus(1'b1, 5'(i), 32'h10000000 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd3, 5'd4);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd9, 5'd31);
    expectVal("fill_r9", 0, 32'h10000009);
    expectVal("fill_r31", 1, 32'h1000001F);
    expectVal("pulse_ready", 3, 32'd1);
    checkOutput();
    applyStimulus(1'b1, 5'd9, 32'hDEADBEEF, 1'b1, 5'd9, 1'b0, 5'd9, 5'd31);
    expectVal("clear_raw_no_bypass", 0, 32'h10000009);
    expectVal("clear_raw_r31", 1, 32'h1000001F);
    expectVal("clear_busy_forced", 2, 32'h3);
    checkOutput();
    measured = 1;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1'b1, 5'd9, 32'hDEADBEEF, 1'b1, 5'd9, 1'b0, 5'd9, 5'd31);
      #1;
      if (ready) begin
        write_enable = 1'b0;
        issue_valid  = 1'b0;
        break;
      end
      measured++;
    end
    expectVal("clear_len", 4, 32'd32);
    checkOutput();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd31);
    expectVal("post_clear_r9", 0, 32'h0);
    expectVal("post_clear_r31", 1, 32'h0);
    expectVal("post_clear_busy", 2, 32'h0);
    checkOutput();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd7);
    expectVal("post_clear_r1", 0, 32'h0);
    expectVal("post_clear_r7", 1, 32'h0);
    expectVal("post_clear_busy7", 2, 32'h0);
    checkOutput();

    $display("[TB] reset during second clear");
    applyStimulus(1'b1, 5'd20, 32'h0BADF00D, 1'b0, 5'd0, 1'b0, 5'd20, 5'd20);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd20, 5'd20);
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd20, 5'd20);
    expectVal("clear2_ready", 3, 32'd0);
    expectVal("clear2_r20_raw", 0, 32'h0BADF00D);
    checkOutput();
    rst = 1'b0;
    expectVal("abort_ready", 3, 32'd1);
    expectVal("abort_r20", 0, 32'h0);
    expectVal("abort_busy", 2, 32'h0);
    checkOutput();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 32'h00C0FFEE, 1'b0, 5'd0, 1'b0, 5'd3, 5'd20);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd20);
    expectVal("after_reset_r3", 0, 32'h00C0FFEE);
    expectVal("after_reset_r20", 1, 32'h0);
    checkOutput();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
